store_narrower: RTL

- Store-side counterpart to the datapath's 16-bit sign extender.
- The extender widens narrow values to 32 bits. This block narrows a 32-bit register value to byte, halfword or word size.
- It then serialises the result, big-endian, onto the byte-wide data-memory write port, one byte per accepted beat.
- Sits between the execute stage's store request and data memory. Flags alignment, size and truncation conditions.

---
 rtl/store_narrower_pkg.sv | 37 +++
 rtl/store_narrower_trunc_check.sv | 36 +++
 rtl/store_narrower.sv | 126 ++++++++++++
 3 files changed

// File: rtl/store_narrower_pkg.sv
// Shared size codes, FSM encoding and byte helpers for the store narrower
// and the load-side sign extender.
package store_narrower_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Index of the most significant byte kept at a given size.
  function automatic logic [1:0] last_idx(
    input logic [1:0] sz
  );
    logic [1:0] r;
    r = 2'd3;
    unique case (sz)
      SZ_BYTE: r = 2'd0;
      SZ_HALF: r = 2'd1;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] pick_byte(
    input logic [31:0] d,
    input logic [1:0]  idx
  );
    return d[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/store_narrower_trunc_check.sv
// Flags a register value that cannot be represented at the store size.
// Purely combinational; word and reserved sizes never truncate.
module trunc_check
  import store_narrower_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic        trunc_err
);

  logic byte_bad;
  logic half_bad;

  always_comb begin
    byte_bad = 1'b0;
    half_bad = 1'b0;
    if (sgn) begin
      byte_bad = data[31:8]  != {24{data[7]}};
      half_bad = data[31:16] != {16{data[15]}};
    end else begin
      byte_bad = data[31:8]  != 24'd0;
      half_bad = data[31:16] != 16'd0;
    end
  end

  always_comb begin
    trunc_err = 1'b0;
    unique case (size)
      SZ_BYTE: trunc_err = byte_bad;
      SZ_HALF: trunc_err = half_bad;
      default: trunc_err = 1'b0;
    endcase
  end

endmodule

// File: rtl/store_narrower.sv
// Narrows a 32-bit store value to byte/half/word and streams it
// big-endian onto a byte-wide memory write port.
module store_narrower
  import store_narrower_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       data_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [1:0]        size,
  input  logic              sgn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              size_err,
  output logic              align_err,
  output logic              trunc_err
);

  state_t            state;
  logic [31:0]       data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [1:0]        k;
  logic [1:0]        last;

  logic              se_in;
  logic              ae_in;
  logic [1:0]        last_in;
  logic [1:0]        k_nx;

  assign se_in   = size == SZ_RSVD;
  assign ae_in   = (size == SZ_HALF && addr_in[0])
                || (size == SZ_WORD && addr_in[1:0] != 2'b00);
  assign last_in = last_idx(size);
  assign k_nx    = k + 2'd1;

  // Evaluated on the captured request so the flag holds until the next start.
  trunc_check u_trunc (
    .data      (data_q),
    .size      (size_q),
    .sgn       (sgn_q),
    .trunc_err (trunc_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      data_q    <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      sgn_q     <= 1'b0;
      k         <= '0;
      last      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      size_err  <= 1'b0;
      align_err <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            data_q    <= data_in;
            addr_q    <= addr_in;
            size_q    <= size;
            sgn_q     <= sgn;
            last      <= last_in;
            k         <= '0;
            size_err  <= se_in;
            align_err <= ae_in;
            busy      <= 1'b1;
            if (se_in || ae_in) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state     <= ST_WRITE;
              mem_we    <= 1'b1;
              mem_addr  <= addr_in;
              mem_wdata <= pick_byte(data_in, last_in);
            end
          end
        end
        ST_WRITE: begin
          if (mem_ready) begin
            if (k == last) begin
              state     <= ST_DONE;
              mem_we    <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
              done      <= 1'b1;
            end else begin
              k         <= k_nx;
              mem_addr  <= addr_q + ADDR_W'(k_nx);
              mem_wdata <= pick_byte(data_q, last - k_nx);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
